spi_sram_cmd_ctrl: RTL
======================

Name: spi_sram_cmd_ctrl

Overview:
Byte-level command sequencer between the SPI shift stages and the SRAM. It consumes each byte assembled by the serial-to-parallel stage and decodes opcode, address and data phases. It drives SRAM read/write strobes with an auto-incrementing address, and loads read data into the parallel-to-serial stage for return to the master. One instance per SPI slave port, clocked on SCK.

Parameters:
ADDR_W, 8, SRAM address width; address wraps modulo 2^ADDR_W
DATA_W, 8, byte width; equals SPI shift width
OP_WRITE, 8'h02, write-sequence opcode
OP_READ, 8'h03, read-sequence opcode

Ports:
SCK  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
cs_n  in  1  chip select, active low; high = abort/idle
rx_byte  in  DATA_W  byte from deserializer, valid with rx_valid
rx_valid  in  1  one-cycle pulse, full byte received
sram_rdata  in  DATA_W  SRAM read data, valid 1 cycle after sram_re
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_we  out  1  one-cycle write strobe
sram_re  out  1  one-cycle read strobe
tx_byte  out  DATA_W  byte for serializer
tx_load  out  1  one-cycle pulse, serializer loads tx_byte
busy  out  1  high in any state other than IDLE
err  out  1  one-cycle pulse on unknown opcode

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all outputs 0, internal addr=0, op=none. Takes effect immediately mid-transaction; no strobe may be emitted in the reset cycle.
- States: IDLE, CMD, ADDR, WR_DATA, RD_WAIT, RD_DATA, IGNORE.
- IDLE: cs_n=0 -> CMD next edge.
- CMD: on rx_valid, rx_byte==OP_WRITE -> ADDR (op=WR); ==OP_READ -> ADDR (op=RD); other -> IGNORE plus err pulse the same edge.
- ADDR: on rx_valid latch addr=rx_byte[ADDR_W-1:0]. If op=WR -> WR_DATA. If op=RD -> assert sram_re with sram_addr=addr on the next cycle, then -> RD_WAIT.
- RD_WAIT: one cycle; capture tx_byte=sram_rdata, pulse tx_load, addr<=addr+1 -> RD_DATA. Latency: rx_valid of the address byte to tx_load = 3 edges.
- RD_DATA: each rx_valid (dummy byte boundary) issues sram_re at the current addr -> RD_WAIT. Incoming rx_byte is ignored.
- WR_DATA: each rx_valid pulses sram_we for one cycle, with sram_addr=addr and sram_wdata=rx_byte on the same cycle. addr<=addr+1 after.
- Address wrap: 2^ADDR_W-1 increments to 0 and the sequence continues; no error.
- IGNORE: stay until cs_n=1; no SRAM strobes and no tx_load.
- cs_n=1 in any non-IDLE state -> IDLE next edge. All strobes are suppressed that cycle, even if rx_valid is simultaneously high. A partially handled read (pending RD_WAIT) is dropped without tx_load.
- sram_we and sram_re are never high together. tx_byte holds its value until the next tx_load.
- rx_valid while IDLE is ignored.

Decomposition:
- Shared package spi_sram_pkg holds:
  - opcode constants OP_WRITE and OP_READ;
  - state encoding constants (3-bit);
  - DATA_W and ADDR_W defaults.
- One natural sub-module: spi_addr_ctr. It loads, increments and wraps the address, with inputs load, inc, d and output q, and async reset.

Test Plan:
- Write burst: cs_n=0; bytes 02,10,AA,BB,CC -> sram_we pulses at addr 10/11/12 with data AA/BB/CC; busy=1 throughout.
- Read burst: after the write burst, send 03,10 then 3 dummy bytes -> tx_byte sequence AA,BB,CC,(addr13 content), each tx_load 3 edges after its rx_valid.
- Wrap: write 02,FF,11,22 -> we at FF data 11, then at 00 data 22.
- Bad opcode: byte 7E -> err pulse once. Subsequent bytes cause no we/re/tx_load; cs_n=1 -> IDLE, busy=0.
- Abort: cs_n rises on the same edge as rx_valid of a write data byte -> no sram_we, state IDLE. The next transaction starts cleanly at CMD.
- Reset mid-read: rst_n=0 during RD_WAIT -> all outputs 0 immediately, no tx_load; after release, IDLE with addr=0.

Source files
------------

// File: rtl/spi_sram_pkg.sv
// Shared definitions for the SPI-to-SRAM command sequencer.
//   DEF_ADDR_W / DEF_DATA_W : default address and byte widths
//   OP_WRITE / OP_READ      : command opcodes
//   state_t                 : 3-bit sequencer state encoding
//   op_t                    : latched operation kind for the current command
package spi_sram_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;

   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_READ  = 8'h03;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD     = 3'd1,
      ST_ADDR    = 3'd2,
      ST_WR_DATA = 3'd3,
      ST_RD_WAIT = 3'd4,
      ST_RD_DATA = 3'd5,
      ST_IGNORE  = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      OPK_NONE = 2'd0,
      OPK_WR   = 2'd1,
      OPK_RD   = 2'd2
   } op_t;

endpackage

// File: rtl/spi_sram_cmd_ctrl_if.sv
// Bundle of the sequencer's SPI byte-side and SRAM-side signals.
//   master : the sequencer (consumes rx bytes / SRAM read data, drives
//            SRAM strobes, tx load, busy and err)
//   slave  : the surrounding shift stages and SRAM
interface spi_sram_cmd_ctrl_if
   import spi_sram_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              cs_n;
   logic [DATA_W-1:0] rx_byte;
   logic              rx_valid;
   logic [DATA_W-1:0] sram_rdata;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic              sram_we;
   logic              sram_re;
   logic [DATA_W-1:0] tx_byte;
   logic              tx_load;
   logic              busy;
   logic              err;

   modport master (
      input  cs_n, rx_byte, rx_valid, sram_rdata,
      output sram_addr, sram_wdata, sram_we, sram_re, tx_byte, tx_load, busy, err
   );

   modport slave (
      output cs_n, rx_byte, rx_valid, sram_rdata,
      input  sram_addr, sram_wdata, sram_we, sram_re, tx_byte, tx_load, busy, err
   );

endinterface

// File: rtl/spi_addr_ctr.sv
// Auto-incrementing SRAM address register.
//   clk, rst_n : clock, async active-low reset (q clears to 0)
//   load, d    : load q with d (has priority over inc)
//   inc        : q <= q + 1, wrapping modulo 2^ADDR_W
//   q          : current address
module spi_addr_ctr
   import spi_sram_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] d,
   output logic [ADDR_W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    q <= '0;
      else if (load) q <= d;
      else if (inc)  q <= q + 1'b1;
   end

endmodule

// File: rtl/spi_sram_cmd_ctrl.sv
// Byte-level command sequencer between the SPI shift stages and the SRAM.
// Decodes opcode / address / data bytes, drives SRAM strobes with an
// auto-incrementing address and hands read data to the serializer.
//   SCK   : SPI clock, all state on posedge
//   rst_n : async active-low reset
//   bus   : master side of spi_sram_cmd_ctrl_if (cs_n, rx_byte/rx_valid,
//           sram_* strobes and data, tx_byte/tx_load, busy, err)
// Read timing: rx_valid of the address (or dummy) byte at edge N,
// sram_re registered at N, SRAM data captured and tx_load raised at N+2.
module spi_sram_cmd_ctrl #(
   parameter int                ADDR_W   = spi_sram_pkg::DEF_ADDR_W,
   parameter int                DATA_W   = spi_sram_pkg::DEF_DATA_W,
   parameter logic [DATA_W-1:0] OP_WRITE = spi_sram_pkg::OP_WRITE,
   parameter logic [DATA_W-1:0] OP_READ  = spi_sram_pkg::OP_READ
) (
   input  logic                SCK,
   input  logic                rst_n,
   spi_sram_cmd_ctrl_if.master bus
);
   import spi_sram_pkg::*;

   state_t            state;
   op_t               op;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] sram_addr_r;
   logic [DATA_W-1:0] sram_wdata_r;
   logic              sram_we_r;
   logic              sram_re_r;
   logic [DATA_W-1:0] tx_byte_r;
   logic              tx_load_r;
   logic              err_r;

   logic              abort;
   logic              addr_load;
   logic              addr_inc;

   // Deselect wins over everything else in a non-idle state.
   assign abort = (state != ST_IDLE) && bus.cs_n;

   // In ADDR/RD_DATA a high sram_re marks the strobe cycle; bytes arriving
   // then are not treated as new address/dummy bytes.
   assign addr_load = !abort && (state == ST_ADDR) && !sram_re_r && bus.rx_valid;
   assign addr_inc  = !abort && (((state == ST_WR_DATA) && bus.rx_valid) ||
                                 (state == ST_RD_WAIT));

   spi_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
      .clk   (SCK),
      .rst_n (rst_n),
      .load  (addr_load),
      .inc   (addr_inc),
      .d     (bus.rx_byte[ADDR_W-1:0]),
      .q     (addr)
   );

   always_ff @(posedge SCK or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         op           <= OPK_NONE;
         sram_addr_r  <= '0;
         sram_wdata_r <= '0;
         sram_we_r    <= 1'b0;
         sram_re_r    <= 1'b0;
         tx_byte_r    <= '0;
         tx_load_r    <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         // Strobes are single-cycle pulses unless re-armed below.
         sram_we_r <= 1'b0;
         sram_re_r <= 1'b0;
         tx_load_r <= 1'b0;
         err_r     <= 1'b0;

         if (abort) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (!bus.cs_n) state <= ST_CMD;
               end

               ST_CMD: begin
                  if (bus.rx_valid) begin
                     if (bus.rx_byte == OP_WRITE) begin
                        op    <= OPK_WR;
                        state <= ST_ADDR;
                     end else if (bus.rx_byte == OP_READ) begin
                        op    <= OPK_RD;
                        state <= ST_ADDR;
                     end else begin
                        err_r <= 1'b1;
                        state <= ST_IGNORE;
                     end
                  end
               end

               ST_ADDR: begin
                  if (sram_re_r) begin
                     // strobe cycle done, SRAM data arrives next cycle
                     state <= ST_RD_WAIT;
                  end else if (bus.rx_valid) begin
                     if (op == OPK_WR) begin
                        state <= ST_WR_DATA;
                     end else begin
                        sram_re_r   <= 1'b1;
                        sram_addr_r <= bus.rx_byte[ADDR_W-1:0];
                     end
                  end
               end

               ST_WR_DATA: begin
                  if (bus.rx_valid) begin
                     sram_we_r    <= 1'b1;
                     sram_addr_r  <= addr;
                     sram_wdata_r <= bus.rx_byte;
                  end
               end

               ST_RD_WAIT: begin
                  tx_byte_r <= bus.sram_rdata;
                  tx_load_r <= 1'b1;
                  state     <= ST_RD_DATA;
               end

               ST_RD_DATA: begin
                  // dummy byte content is irrelevant, only its boundary
                  if (sram_re_r) begin
                     state <= ST_RD_WAIT;
                  end else if (bus.rx_valid) begin
                     sram_re_r   <= 1'b1;
                     sram_addr_r <= addr;
                  end
               end

               ST_IGNORE: ;

               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.sram_addr  = sram_addr_r;
   assign bus.sram_wdata = sram_wdata_r;
   assign bus.sram_we    = sram_we_r;
   assign bus.sram_re    = sram_re_r;
   assign bus.tx_byte    = tx_byte_r;
   assign bus.tx_load    = tx_load_r;
   assign bus.err        = err_r;
   assign bus.busy       = (state != ST_IDLE);

endmodule
